ddr4_v2_2_20_axi_mport_cmd_arbiter: RTL

//  N-port command arbiter in front of the MC app interface. Each port carries an already

---
 rtl/ddr4_v2_2_20_axi_mport_cmd_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ddr4_v2_2_20_axi_mport_cmd_arbiter.sv
// N-port MC command arbiter: starved > high-QoS > round-robin, with a grant that stays
// locked to one port from its first beat until its req_last beat is accepted.
module ddr4_v2_2_20_axi_mport_cmd_arbiter #(
   parameter int C_NUM_PORTS        = 4,
   parameter int C_MC_ADDR_WIDTH    = 30,
   parameter int C_STARVE_LIMIT     = 64,
   parameter int C_STARVE_CNT_WIDTH = 7,
   parameter int C_QOS_HI_THRESH    = 8,
   localparam int IDX_W             = $clog2(C_NUM_PORTS)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [C_NUM_PORTS-1:0]                 req_en,
   input  logic [C_NUM_PORTS-1:0]                 req_last,
   input  logic [3*C_NUM_PORTS-1:0]               req_instr,
   input  logic [C_MC_ADDR_WIDTH*C_NUM_PORTS-1:0] req_addr,
   input  logic [4*C_NUM_PORTS-1:0]               req_qos,
   input  logic [C_NUM_PORTS-1:0]                 req_ap,
   output logic [C_NUM_PORTS-1:0]                 req_full,
   output logic                                   mc_app_en,
   output logic [2:0]                             mc_app_cmd,
   output logic [C_MC_ADDR_WIDTH-1:0]             mc_app_addr,
   output logic                                   mc_app_hi_pri,
   output logic                                   mc_app_autoprecharge,
   input  logic                                   mc_app_rdy,
   output logic [IDX_W-1:0]                       grant_idx
);

   localparam logic [C_STARVE_CNT_WIDTH-1:0] LIMIT  = C_STARVE_CNT_WIDTH'(C_STARVE_LIMIT);
   localparam logic [3:0]                    QOS_HI = 4'(C_QOS_HI_THRESH);

   logic                          locked;
   logic [IDX_W-1:0]              owner;
   logic [IDX_W-1:0]              rr_ptr;
   logic [IDX_W-1:0]              winner;
   logic [C_STARVE_CNT_WIDTH-1:0] starve_cnt [C_NUM_PORTS];
   logic [C_NUM_PORTS-1:0]        starved;
   logic [C_NUM_PORTS-1:0]        hi_qos;
   logic [C_NUM_PORTS-1:0]        tier1;
   logic [C_NUM_PORTS-1:0]        tier2;
   logic                          accept;

   // First set bit of mask at or after ptr, scanning cyclically.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [C_NUM_PORTS-1:0] mask,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] sel;
      logic [IDX_W-1:0] idx;
      logic             found;
      sel   = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < C_NUM_PORTS; k++) begin
         if (!found && mask[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
         idx = (idx == IDX_W'(C_NUM_PORTS - 1)) ? '0 : idx + IDX_W'(1);
      end
      return sel;
   endfunction

   function automatic logic [C_STARVE_CNT_WIDTH-1:0] sat_inc(input logic [C_STARVE_CNT_WIDTH-1:0] cnt);
      return (cnt == LIMIT) ? cnt : cnt + C_STARVE_CNT_WIDTH'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
         starved[i] = (starve_cnt[i] == LIMIT);
         hi_qos[i]  = (req_qos[4*i +: 4] >= QOS_HI);
      end
   end

   assign tier1 = req_en & starved;
   assign tier2 = req_en & hi_qos;

   always_comb begin
      winner    = owner;
      mc_app_en = 1'b0;
      if (locked) begin
         winner    = owner;
         mc_app_en = req_en[owner];
      end else if (|req_en) begin
         mc_app_en = 1'b1;
         if (|tier1)
            winner = rr_pick(tier1, rr_ptr);
         else if (|tier2)
            winner = rr_pick(tier2, rr_ptr);
         else
            winner = rr_pick(req_en, rr_ptr);
      end
   end

   assign accept               = mc_app_en & mc_app_rdy;
   assign grant_idx            = winner;
   assign mc_app_cmd           = req_instr[3*winner +: 3];
   assign mc_app_addr          = req_addr[C_MC_ADDR_WIDTH*winner +: C_MC_ADDR_WIDTH];
   assign mc_app_hi_pri        = req_en[winner] & (starved[winner] | hi_qos[winner]);
   assign mc_app_autoprecharge = req_ap[winner] & req_last[winner];

   always_comb begin
      for (int i = 0; i < C_NUM_PORTS; i++)
         req_full[i] = ~(accept && (winner == IDX_W'(i)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         locked <= 1'b0;
         owner  <= '0;
         rr_ptr <= '0;
         for (int i = 0; i < C_NUM_PORTS; i++)
            starve_cnt[i] <= '0;
      end else begin
         if (accept) begin
            if (req_last[winner]) begin
               locked <= 1'b0;
               rr_ptr <= (winner == IDX_W'(C_NUM_PORTS - 1)) ? '0 : winner + IDX_W'(1);
            end else begin
               locked <= 1'b1;
               owner  <= winner;
            end
         end
         // An accepted non-last beat neither waits nor finishes, so its counter holds.
         for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (!req_full[i]) begin
               if (req_last[i])
                  starve_cnt[i] <= '0;
            end else if (req_en[i]) begin
               starve_cnt[i] <= sat_inc(starve_cnt[i]);
            end
         end
      end
   end

endmodule
